mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single memory port between the instruction-fetch unit and the load/store unit (`mem`). Each requester sees a private `decoupled` request/response pair. The arbiter grants one transaction at a time, forwards the request to the memory port, and routes the response back to the owner. Supported response timing is either same-cycle (zero latency) or any later cycle. It sits between the pipeline's fetch/exec stages and the memory/bus wrapper.

## Interface
- `LSU_PRIO`, default 0: 0 = round-robin between requesters; 1 = fixed priority, LSU always wins ties.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `if_req` decoupled.in, data `{a, be, d, we}` (addr, 4, mtrans, 1): fetch request.
- `if_resp` decoupled.out, mtrans (32): fetch response.
- `lsu_req` decoupled.in, same payload: load/store request.
- `lsu_resp` decoupled.out, mtrans: load/store response.
- `mem_req` decoupled.out, same payload: to memory.
- `mem_resp` decoupled.in, mtrans: from memory.
- `err_stray` output 1: registered one-cycle pulse; a response arrived with no owner and was dropped.

## Operation
- State: `state` ∈ {IDLE, BUSY}, `owner` ∈ {IF, LSU}, `last_grant` ∈ {IF, LSU}.
- Reset values: `state`=IDLE, `owner`=IF, `last_grant`=IF, `err_stray`=0.
- Because `last_grant` resets to IF, the first tie goes to LSU.
- Selection, IDLE only, combinational:
  - If exactly one requester is valid, it is `sel`.
  - If both are valid and `LSU_PRIO`=1, `sel`=LSU.
  - If both are valid and `LSU_PRIO`=0, `sel` is the one that is not `last_grant`.
- IDLE outputs:
  - `mem_req.valid` = `sel` valid.
  - `mem_req.data` = `sel` payload.
  - `sel`.req.ready = `mem_req.ready`.
  - The other requester's `req.ready` = 0.
- Grant handshake (IDLE, `mem_req.valid && mem_req.ready`):
  - `last_grant` <= `sel`.
  - If `mem_resp.valid` in the same cycle (zero latency): forward `mem_resp.data` to `sel`.resp with valid=1, and set `mem_resp.ready` = `sel`.resp.ready.
    - If `sel`.resp.ready=1: stay IDLE.
    - Otherwise: go to BUSY with `owner`=`sel`.
  - If `mem_resp.valid`=0: go to BUSY with `owner`=`sel`.
- BUSY:
  - `mem_req.valid`=0 and both `req.ready`=0.
  - `owner`.resp.valid = `mem_resp.valid` and `owner`.resp.data = `mem_resp.data`.
  - `mem_resp.ready` = `owner`.resp.ready.
  - The non-owner's resp.valid = 0.
  - On response handshake, go to IDLE.
- Stray response (IDLE, `mem_resp.valid`=1, no grant handshake this cycle): `mem_resp.ready`=1, the data is dropped, and `err_stray`=1 next cycle.
- A requester must hold its payload stable while valid and not ready. The arbiter does not register the payload. It relies on the owner keeping `req` asserted until the response, which is the `mem` unit's behaviour.
- `we`, `be`, `a` and `d` pass through unmodified. The arbiter performs no alignment checks.

## Timing
- Request path is combinational. `mem_req` is valid in the same cycle the selected requester is valid, with zero added latency.
- Response path is combinational from `mem_resp` to the owner's resp.
- After a non-zero-latency response completes, the arbiter returns to IDLE. The next grant can occur in the following cycle, so there is a one-cycle bubble.
- Back-to-back zero-latency transactions can complete every cycle.
- Fairness with `LSU_PRIO`=0 and both requesters continuously valid: grants alternate exactly, and neither requester waits more than one transaction.
- Reset asserted mid-transaction:
  - Next cycle, `state`=IDLE and the outstanding transaction is abandoned.
  - A late response then hits the stray path (dropped, `err_stray` pulse).
  - Neither requester's resp.valid is asserted for it.
- Simultaneous `rst` and handshake: reset wins, and no state update from the handshake is kept.

## Test plan
- **Single fetch:** `if_req` a=0x1000, we=0; memory ready, response 0xDEADBEEF after 2 cycles.
  - Required: `mem_req.a`=0x1000 in cycle 0.
  - Required: `if_resp.valid` with 0xDEADBEEF in cycle 2; `lsu_resp.valid` never 1.
  - Required: the next grant is no earlier than cycle 3.
- **Tie, round-robin (`LSU_PRIO`=0):** both requesters valid continuously after reset, 1-cycle memory latency.
  - Required grant order: LSU, IF, LSU, IF.
  - Required: each response is routed to the matching requester.
- **Tie, fixed priority (`LSU_PRIO`=1):** LSU is granted every time and IF is never granted while LSU stays valid.
- **Zero latency:** memory asserts `mem_resp.valid` in the same cycle as `mem_req.ready`, for an LSU store with be=4'b0011, d=0x0000ABCD.
  - Required: `lsu_resp.valid` in the same cycle and `state` stays IDLE.
  - Required: the next request is granted in the next cycle.
- **Response backpressure:** `lsu_resp.ready`=0 for 3 cycles while `mem_resp.valid`=1.
  - Required: `mem_resp.ready`=0 for those cycles.
  - Required: the data is delivered once ready rises; no new grant happens before that.
- **Reset mid-BUSY, then stray:** assert `rst` for 1 cycle during BUSY, then the memory returns a response.
  - Required: the response is dropped, `err_stray`=1 for exactly one cycle, and both resp.valid stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (fetch / load-store) arbiter for one memory port.
//            Combinational request and response paths, one grant at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter bit LSU_PRIO = 1'b0,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    // fetch request / response
    input  logic              i_if_req_valid,
    output logic              o_if_req_ready,
    input  logic [ADDR_W-1:0] i_if_req_a,
    input  logic [3:0]        i_if_req_be,
    input  logic [DATA_W-1:0] i_if_req_d,
    input  logic              i_if_req_we,
    output logic              o_if_resp_valid,
    input  logic              i_if_resp_ready,
    output logic [DATA_W-1:0] o_if_resp_data,
    // load/store request / response
    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready,
    input  logic [ADDR_W-1:0] i_lsu_req_a,
    input  logic [3:0]        i_lsu_req_be,
    input  logic [DATA_W-1:0] i_lsu_req_d,
    input  logic              i_lsu_req_we,
    output logic              o_lsu_resp_valid,
    input  logic              i_lsu_resp_ready,
    output logic [DATA_W-1:0] o_lsu_resp_data,
    // memory port
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_req_a,
    output logic [3:0]        o_mem_req_be,
    output logic [DATA_W-1:0] o_mem_req_d,
    output logic              o_mem_req_we,
    input  logic              i_mem_resp_valid,
    output logic              o_mem_resp_ready,
    input  logic [DATA_W-1:0] i_mem_resp_data,
    output logic              o_err_stray
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic c_REQ_IF  = 1'b0;
    localparam logic c_REQ_LSU = 1'b1;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   w_owner_nxt;
    logic   r_last_grant;
    logic   w_last_grant_nxt;
    logic   r_err_stray;

    logic   w_sel;
    logic   w_sel_valid;
    logic   w_grant;
    logic   w_stray;
    logic   w_rsp_en;
    logic   w_rsp_to;

    // Requester selection; on a tie round-robin favours whoever was not granted last.
    always_comb begin
        w_sel = c_REQ_IF;
        if (i_if_req_valid && !i_lsu_req_valid) begin
            w_sel = c_REQ_IF;
        end else if (i_lsu_req_valid && !i_if_req_valid) begin
            w_sel = c_REQ_LSU;
        end else if (i_if_req_valid && i_lsu_req_valid) begin
            if (LSU_PRIO) begin
                w_sel = c_REQ_LSU;
            end else begin
                w_sel = (r_last_grant == c_REQ_IF) ? c_REQ_LSU : c_REQ_IF;
            end
        end
    end

    assign w_sel_valid = i_if_req_valid | i_lsu_req_valid;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_grant          = 1'b0;
        w_stray          = 1'b0;
        w_rsp_en         = 1'b0;
        w_rsp_to         = r_owner;
        o_mem_req_valid  = 1'b0;
        o_mem_req_a      = i_if_req_a;
        o_mem_req_be     = i_if_req_be;
        o_mem_req_d      = i_if_req_d;
        o_mem_req_we     = i_if_req_we;
        o_if_req_ready   = 1'b0;
        o_lsu_req_ready  = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_mem_req_valid = w_sel_valid;
                if (w_sel == c_REQ_LSU) begin
                    o_mem_req_a     = i_lsu_req_a;
                    o_mem_req_be    = i_lsu_req_be;
                    o_mem_req_d     = i_lsu_req_d;
                    o_mem_req_we    = i_lsu_req_we;
                    o_lsu_req_ready = i_mem_req_ready;
                end else begin
                    o_if_req_ready  = i_mem_req_ready;
                end
                w_grant = w_sel_valid && i_mem_req_ready;
                if (w_grant) begin
                    w_last_grant_nxt = w_sel;
                    w_owner_nxt      = w_sel;
                    w_state_nxt      = S_BUSY;
                    if (i_mem_resp_valid) begin
                        // Zero-latency reply: only stay IDLE if the requester takes it now.
                        w_rsp_en = 1'b1;
                        w_rsp_to = w_sel;
                        if ((w_sel == c_REQ_LSU) ? i_lsu_resp_ready : i_if_resp_ready) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end else if (i_mem_resp_valid) begin
                    w_stray = 1'b1;
                end
            end
            S_BUSY: begin
                w_rsp_en = 1'b1;
                w_rsp_to = r_owner;
                if (i_mem_resp_valid && ((r_owner == c_REQ_LSU) ? i_lsu_resp_ready
                                                                : i_if_resp_ready)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_if_resp_valid  = w_rsp_en && (w_rsp_to == c_REQ_IF)  && i_mem_resp_valid;
    assign o_lsu_resp_valid = w_rsp_en && (w_rsp_to == c_REQ_LSU) && i_mem_resp_valid;
    assign o_if_resp_data   = i_mem_resp_data;
    assign o_lsu_resp_data  = i_mem_resp_data;
    assign o_mem_resp_ready = w_stray | (w_rsp_en && ((w_rsp_to == c_REQ_LSU) ? i_lsu_resp_ready
                                                                               : i_if_resp_ready));
    assign o_err_stray      = r_err_stray;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= c_REQ_IF;
            r_last_grant <= c_REQ_IF;
            r_err_stray  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_err_stray  <= w_stray;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter (round-robin and
//            fixed-priority instances share one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_v, if_rr, if_we, lsu_v, lsu_rr, lsu_we;
    logic [31:0] if_a, if_d, lsu_a, lsu_d, mrsp_d;
    logic [3:0]  if_be, lsu_be;
    logic        mreq_rdy, mrsp_v;

    logic        if_rdy0, lsu_rdy0, ifr_v0, lsur_v0, mreq_v0, mreq_we0, mrsp_rdy0, stray0;
    logic [31:0] ifr_d0, lsur_d0, mreq_a0, mreq_d0;
    logic [3:0]  mreq_be0;
    logic        if_rdy1, lsu_rdy1, ifr_v1, lsur_v1, mreq_v1, mreq_we1, mrsp_rdy1, stray1;
    logic [31:0] ifr_d1, lsur_d1, mreq_a1, mreq_d1;
    logic [3:0]  mreq_be1;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LSU_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .i_if_req_valid(if_v), .o_if_req_ready(if_rdy0), .i_if_req_a(if_a),
        .i_if_req_be(if_be), .i_if_req_d(if_d), .i_if_req_we(if_we),
        .o_if_resp_valid(ifr_v0), .i_if_resp_ready(if_rr), .o_if_resp_data(ifr_d0),
        .i_lsu_req_valid(lsu_v), .o_lsu_req_ready(lsu_rdy0), .i_lsu_req_a(lsu_a),
        .i_lsu_req_be(lsu_be), .i_lsu_req_d(lsu_d), .i_lsu_req_we(lsu_we),
        .o_lsu_resp_valid(lsur_v0), .i_lsu_resp_ready(lsu_rr), .o_lsu_resp_data(lsur_d0),
        .o_mem_req_valid(mreq_v0), .i_mem_req_ready(mreq_rdy), .o_mem_req_a(mreq_a0),
        .o_mem_req_be(mreq_be0), .o_mem_req_d(mreq_d0), .o_mem_req_we(mreq_we0),
        .i_mem_resp_valid(mrsp_v), .o_mem_resp_ready(mrsp_rdy0), .i_mem_resp_data(mrsp_d),
        .o_err_stray(stray0)
    );

    mem_arbiter #(.LSU_PRIO(1'b1)) u_pr (
        .clk(clk), .rst(rst),
        .i_if_req_valid(if_v), .o_if_req_ready(if_rdy1), .i_if_req_a(if_a),
        .i_if_req_be(if_be), .i_if_req_d(if_d), .i_if_req_we(if_we),
        .o_if_resp_valid(ifr_v1), .i_if_resp_ready(if_rr), .o_if_resp_data(ifr_d1),
        .i_lsu_req_valid(lsu_v), .o_lsu_req_ready(lsu_rdy1), .i_lsu_req_a(lsu_a),
        .i_lsu_req_be(lsu_be), .i_lsu_req_d(lsu_d), .i_lsu_req_we(lsu_we),
        .o_lsu_resp_valid(lsur_v1), .i_lsu_resp_ready(lsu_rr), .o_lsu_resp_data(lsur_d1),
        .o_mem_req_valid(mreq_v1), .i_mem_req_ready(mreq_rdy), .o_mem_req_a(mreq_a1),
        .o_mem_req_be(mreq_be1), .o_mem_req_d(mreq_d1), .o_mem_req_we(mreq_we1),
        .i_mem_resp_valid(mrsp_v), .o_mem_resp_ready(mrsp_rdy1), .i_mem_resp_data(mrsp_d),
        .o_err_stray(stray1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_v = 0; lsu_v = 0; mreq_rdy = 0; mrsp_v = 0; mrsp_d = 32'h0;
        if_rr = 1; lsu_rr = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        if_a = 0; if_d = 0; if_be = 4'hF; if_we = 0;
        lsu_a = 0; lsu_d = 0; lsu_be = 4'hF; lsu_we = 0;
        do_reset();
        #1;
        check("rst_err_stray", stray0, 0);
        check("rst_mem_req_valid", mreq_v0, 0);
        check("rst_resp_valid", {ifr_v0, lsur_v0}, 0);

        // Single fetch, 2-cycle memory latency
        tick(); if_v = 1; if_a = 32'h1000; if_we = 0; mreq_rdy = 1; #1;
        check("fetch_c0_valid", mreq_v0, 1);
        check("fetch_c0_addr", mreq_a0, 32'h1000);
        check("fetch_c0_if_ready", if_rdy0, 1);
        check("fetch_c0_lsu_ready", lsu_rdy0, 0);
        tick(); #1;
        check("fetch_c1_no_req", mreq_v0, 0);
        check("fetch_c1_if_ready", if_rdy0, 0);
        check("fetch_c1_resp", {ifr_v0, lsur_v0}, 0);
        tick(); mrsp_v = 1; mrsp_d = 32'hDEADBEEF; #1;
        check("fetch_c2_if_resp_valid", ifr_v0, 1);
        check("fetch_c2_if_resp_data", ifr_d0, 32'hDEADBEEF);
        check("fetch_c2_lsu_resp_valid", lsur_v0, 0);
        check("fetch_c2_mem_resp_ready", mrsp_rdy0, 1);
        check("fetch_c2_no_grant", mreq_v0, 0);
        tick(); mrsp_v = 0; if_a = 32'h1004; mreq_rdy = 0; #1;
        check("fetch_c3_req_again", mreq_v0, 1);
        check("fetch_c3_addr", mreq_a0, 32'h1004);
        check("fetch_c3_ready_follows_mem", if_rdy0, 0);

        // Round-robin tie, 1-cycle latency
        do_reset();
        if_a = 32'h2000; lsu_a = 32'h3000;
        for (int k = 0; k < 4; k++) begin
            tick(); if_v = 1; lsu_v = 1; mreq_rdy = 1; mrsp_v = 0; #1;
            check("rr_grant_addr", mreq_a0, (k % 2 == 0) ? 32'h3000 : 32'h2000);
            check("rr_grant_ready", {lsu_rdy0, if_rdy0}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick(); mrsp_v = 1; mrsp_d = 32'hA0 + k; #1;
            check("rr_resp_route", {lsur_v0, ifr_v0}, (k % 2 == 0) ? 2'b10 : 2'b01);
            check("rr_resp_data", (k % 2 == 0) ? lsur_d0 : ifr_d0, 32'hA0 + k);
        end

        // Fixed priority tie
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick(); if_v = 1; lsu_v = 1; mreq_rdy = 1; mrsp_v = 0; #1;
            check("prio_grant_addr", mreq_a1, 32'h3000);
            check("prio_grant_ready", {lsu_rdy1, if_rdy1}, 2'b10);
            tick(); mrsp_v = 1; mrsp_d = 32'hB0 + k; #1;
            check("prio_resp_route", {lsur_v1, ifr_v1}, 2'b10);
        end

        // Zero-latency LSU store, then a second request the very next cycle
        do_reset();
        tick(); lsu_v = 1; lsu_we = 1; lsu_be = 4'b0011; lsu_d = 32'h0000ABCD; lsu_a = 32'h4000;
        mreq_rdy = 1; mrsp_v = 1; mrsp_d = 32'h0; #1;
        check("zl_be", mreq_be0, 4'b0011);
        check("zl_d", mreq_d0, 32'h0000ABCD);
        check("zl_we", mreq_we0, 1);
        check("zl_lsu_resp_valid", lsur_v0, 1);
        check("zl_if_resp_valid", ifr_v0, 0);
        check("zl_mem_resp_ready", mrsp_rdy0, 1);
        tick(); lsu_a = 32'h4004; mrsp_d = 32'h1; #1;
        check("zl_next_grant_valid", mreq_v0, 1);
        check("zl_next_grant_ready", lsu_rdy0, 1);
        check("zl_next_resp_valid", lsur_v0, 1);
        tick(); idle_inputs(); lsu_we = 0; lsu_be = 4'hF; #1;
        check("zl_no_stray", stray0, 0);

        // Response backpressure on LSU
        do_reset();
        tick(); lsu_v = 1; lsu_a = 32'h5000; mreq_rdy = 1; #1;
        check("bp_grant", lsu_rdy0, 1);
        for (int k = 0; k < 3; k++) begin
            tick(); lsu_v = 0; if_v = 1; if_a = 32'h5100; mrsp_v = 1; mrsp_d = 32'h12345678;
            lsu_rr = 0; #1;
            check("bp_mem_resp_ready_low", mrsp_rdy0, 0);
            check("bp_no_new_grant", {mreq_v0, if_rdy0}, 2'b00);
            check("bp_resp_valid_held", lsur_v0, 1);
        end
        tick(); lsu_rr = 1; #1;
        check("bp_deliver_valid", lsur_v0, 1);
        check("bp_deliver_data", lsur_d0, 32'h12345678);
        check("bp_deliver_ready", mrsp_rdy0, 1);
        check("bp_deliver_no_grant", mreq_v0, 0);
        tick(); mrsp_v = 0; mreq_rdy = 0; #1;
        check("bp_after_req", {mreq_v0, mreq_a0}, {1'b1, 32'h5100});

        // Reset during BUSY, then a late response is a stray
        do_reset();
        tick(); if_v = 1; if_a = 32'h6000; mreq_rdy = 1; #1;
        check("rb_grant", if_rdy0, 1);
        tick(); if_v = 0; mreq_rdy = 0; rst = 1; #1;
        tick(); rst = 0; mrsp_v = 1; mrsp_d = 32'h00000BAD; #1;
        check("rb_resp_valid_both", {ifr_v0, lsur_v0}, 2'b00);
        check("rb_mem_resp_ready", mrsp_rdy0, 1);
        check("rb_stray_not_yet", stray0, 0);
        tick(); mrsp_v = 0; #1;
        check("rb_stray_pulse", stray0, 1);
        check("rb_resp_valid_after", {ifr_v0, lsur_v0}, 2'b00);
        tick(); #1;
        check("rb_stray_one_cycle", stray0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
